// File: rtl/debounce_entrada_io.sv
// debounce_entrada_io: synchronizes and debounces the board key, latching the data switches on each accepted press.
// Optional DEBOUNCE_GATE_PEDIDO_EN: capture only while the CPU requests input (pedidoIN=1).
module debounce_entrada_io #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botaoPlaca,
  input  logic [3:0] entradaDeDadosIO,
  input  logic       pedidoIN,
  input  logic       dadoLido,
  output logic       botaoIN,
  output logic       dadoValido,
  output logic [3:0] dadoCapturado,
  output logic       pulsoBotao,
  output logic       sobrescrita
);
  typedef enum logic [1:0] {SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTURA} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q;
  logic [1:0] btn_sync_q;
  logic [3:0] sw_meta_q, sw_sync_q, dado_q;
  logic press_q, pulso_q, valido_q, sobre_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done, accept, capture;
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign done = cnt_q == LAST;
  assign accept = (state_q == CONFIRMA_PRESS) && press_q && done;
`ifdef DEBOUNCE_GATE_PEDIDO_EN
  assign capture = accept && pedidoIN;
`else
  logic unused_pedido;
  assign unused_pedido = pedidoIN;
  assign capture = accept;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_sync_q <= 2'b11;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      press_q    <= 1'b0;
      state_q    <= SOLTO;
      cnt_q      <= '0;
      pulso_q    <= 1'b0;
      valido_q   <= 1'b0;
      dado_q     <= '0;
      sobre_q    <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], botaoPlaca};
      sw_meta_q  <= entradaDeDadosIO;
      sw_sync_q  <= sw_meta_q;
      press_q    <= ~btn_sync_q[1];
      pulso_q    <= accept;
      cnt_q      <= cnt_d;
      case (state_q)
        SOLTO:
          if (press_q) begin
            state_q <= CONFIRMA_PRESS;
            cnt_q   <= '0;
          end
        CONFIRMA_PRESS:
          if (!press_q || done) begin
            state_q <= press_q ? PRESSIONADO : SOLTO;
            cnt_q   <= '0;
          end
        PRESSIONADO:
          if (!press_q) begin
            state_q <= CONFIRMA_SOLTURA;
            cnt_q   <= '0;
          end
        default:
          if (press_q || done) begin
            state_q <= press_q ? PRESSIONADO : SOLTO;
            cnt_q   <= '0;
          end
      endcase
      // an ack on the capture edge consumes the old data, so it is not an overrun
      if (capture) begin
        dado_q   <= sw_sync_q;
        valido_q <= 1'b1;
        if (valido_q && !dadoLido) sobre_q <= 1'b1;
      end else if (dadoLido) begin
        valido_q <= 1'b0;
      end
    end
  end
  assign botaoIN       = valido_q;
  assign dadoValido    = valido_q;
  assign dadoCapturado = dado_q;
  assign pulsoBotao    = pulso_q;
  assign sobrescrita   = sobre_q;
endmodule

// File: tb/tb_debounce_entrada_io.sv
// tb_debounce_entrada_io: scoreboard bench; stimulus queues expected pulses and state snapshots, a negedge monitor compares.
module tb_debounce_entrada_io;
  logic clock = 1'b0, reset = 1'b0, botaoPlaca = 1'b1, pedidoIN = 1'b1, dadoLido = 1'b0;
  logic [3:0] entradaDeDadosIO = 4'h0;
  logic botaoIN, dadoValido, pulsoBotao, sobrescrita;
  logic [3:0] dadoCapturado;
  int cyc = 0, errors = 0, checks = 0, sid = 0;
  logic fin = 1'b0;
  typedef struct {int cyc; logic [3:0] dado; logic val; logic sob;} pev_t;
  typedef struct {int id; logic [3:0] dado; logic val; logic sob;} st_t;
  pev_t exp_q[$];
  st_t st_q[$];

  debounce_entrada_io #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .botaoPlaca(botaoPlaca), .entradaDeDadosIO(entradaDeDadosIO),
    .pedidoIN(pedidoIN), .dadoLido(dadoLido), .botaoIN(botaoIN), .dadoValido(dadoValido),
    .dadoCapturado(dadoCapturado), .pulsoBotao(pulsoBotao), .sobrescrita(sobrescrita)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    pev_t e;
    st_t s;
    if (pulsoBotao) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_pulse at cyc=%0d dado=%h val=%b sob=%b", cyc, dadoCapturado, dadoValido, sobrescrita);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || dadoCapturado != e.dado || dadoValido != e.val || botaoIN != e.val || sobrescrita != e.sob) begin
          errors++;
          $display("FAIL pulse: got cyc=%0d dado=%h val=%b in=%b sob=%b, want cyc=%0d dado=%h val=%b sob=%b",
                   cyc, dadoCapturado, dadoValido, botaoIN, sobrescrita, e.cyc, e.dado, e.val, e.sob);
        end
      end
    end
    if (st_q.size() != 0) begin
      s = st_q.pop_front();
      checks++;
      if (pulsoBotao || dadoCapturado != s.dado || dadoValido != s.val || botaoIN != s.val || sobrescrita != s.sob) begin
        errors++;
        $display("FAIL state#%0d: got pulse=%b dado=%h val=%b in=%b sob=%b, want pulse=0 dado=%h val=%b sob=%b",
                 s.id, pulsoBotao, dadoCapturado, dadoValido, botaoIN, sobrescrita, s.dado, s.val, s.sob);
      end
    end
    if (fin) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_pulse: %0d expected pulses never seen, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic st(input logic [3:0] d, input logic v, input logic s);
    st_q.push_back('{sid, d, v, s});
    sid++;
  endtask

  task automatic ack();
    dadoLido = 1'b1;
    tick(1);
    dadoLido = 1'b0;
  endtask

  task automatic press(input logic [3:0] sw, input logic [3:0] d, input logic v, input logic s);
    entradaDeDadosIO = sw;
    botaoPlaca = 1'b0;
    exp_q.push_back('{cyc + 8, d, v, s});
    tick(12);
    botaoPlaca = 1'b1;
    tick(10);
  endtask

  initial begin
    tick(2);
    st(4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);
    st(4'h0, 1'b0, 1'b0);
    // single press held long: one pulse only
    entradaDeDadosIO = 4'hA;
    botaoPlaca = 1'b0;
    exp_q.push_back('{cyc + 8, 4'hA, 1'b1, 1'b0});
    tick(60);
    st(4'hA, 1'b1, 1'b0);
    botaoPlaca = 1'b1;
    tick(10);
    ack();
    st(4'hA, 1'b0, 1'b0);
    // bounce: never stable long enough
    entradaDeDadosIO = 4'hF;
    repeat (5) begin
      botaoPlaca = 1'b0;
      tick(3);
      botaoPlaca = 1'b1;
      tick(1);
    end
    tick(10);
    st(4'hA, 1'b0, 1'b0);
    // handshake
    press(4'h3, 4'h3, 1'b1, 1'b0);
    ack();
    st(4'h3, 1'b0, 1'b0);
    press(4'h5, 4'h5, 1'b1, 1'b0);
    ack();
    st(4'h5, 1'b0, 1'b0);
    // ack coincident with the accept edge while old data is pending
    press(4'h6, 4'h6, 1'b1, 1'b0);
    entradaDeDadosIO = 4'h7;
    botaoPlaca = 1'b0;
    exp_q.push_back('{cyc + 8, 4'h7, 1'b1, 1'b0});
    tick(7);
    dadoLido = 1'b1;
    tick(1);
    dadoLido = 1'b0;
    tick(4);
    botaoPlaca = 1'b1;
    tick(10);
    st(4'h7, 1'b1, 1'b0);
    ack();
    st(4'h7, 1'b0, 1'b0);
    // overrun
    press(4'h1, 4'h1, 1'b1, 1'b0);
    press(4'h2, 4'h2, 1'b1, 1'b1);
    ack();
    st(4'h2, 1'b0, 1'b1);
    tick(5);
    st(4'h2, 1'b0, 1'b1);
    // reset during CONFIRMA_PRESS with the key still held
    entradaDeDadosIO = 4'h9;
    botaoPlaca = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(1);
    st(4'h0, 1'b0, 1'b0);
    tick(1);
    reset = 1'b1;
    exp_q.push_back('{cyc + 8, 4'h9, 1'b1, 1'b0});
    tick(12);
    botaoPlaca = 1'b1;
    tick(10);
    ack();
    st(4'h9, 1'b0, 1'b0);
    // pedidoIN gating
    pedidoIN = 1'b0;
`ifdef DEBOUNCE_GATE_PEDIDO_EN
    press(4'hC, 4'h9, 1'b0, 1'b0);
    pedidoIN = 1'b1;
    press(4'hD, 4'hD, 1'b1, 1'b0);
`else
    press(4'hC, 4'hC, 1'b1, 1'b0);
    pedidoIN = 1'b1;
    press(4'hD, 4'hD, 1'b1, 1'b1);
`endif
    tick(2);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary, want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/debounce_entrada_io.md
# debounce_entrada_io

Conditions the raw board push-button and 4-bit data switches before the CPU's `EntradaSaida` path. It sits directly upstream of the CPU's `botaoIN`/`entradaDeDadosIO` inputs and replaces the raw `botaoPlaca` connection. Each debounced press produces exactly one event and latches the switch value at that press. The latched value is held with a valid/ack handshake until the CPU's IN instruction consumes it.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable synchronized samples required to accept a level change; 10 ms at 50 MHz; minimum 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clock` in 1: single system clock; all logic on posedge.
- `reset` in 1: synchronous, active-low; `reset`=0 at a posedge resets the block.
- `botaoPlaca` in 1: raw board key, active-low (0 = pressed), asynchronous.
- `entradaDeDadosIO` in 4: raw data switches, asynchronous.
- `pedidoIN` in 1: CPU is executing IN and waiting for data.
- `dadoLido` in 1: one-cycle ack; the CPU has consumed `dadoCapturado`.
- `botaoIN` out 1: equals `dadoValido`; drives the CPU's `botaoIN`.
- `dadoValido` out 1: `dadoCapturado` holds unconsumed data.
- `dadoCapturado` out 4: switch value latched at the accepted press.
- `pulsoBotao` out 1: one-cycle pulse per debounced press.
- `sobrescrita` out 1: sticky overrun flag.

## Operation

- **Synchronizers.**
  - `botaoPlaca` passes through a 2-flop synchronizer; reset value 1 (released). The result is inverted internally to `press_s` (1 = pressed).
  - `entradaDeDadosIO` passes through a 2-flop synchronizer per bit; reset value 0.
- **FSM states:** SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTURA. Reset state is SOLTO.
  - SOLTO: `press_s`=1 → CONFIRMA_PRESS, counter cleared to 0.
  - CONFIRMA_PRESS:
    - `press_s`=0 (bounce) → SOLTO, counter cleared.
    - Otherwise the counter increments.
    - When the counter reaches `DEBOUNCE_CYCLES`-1 with `press_s`=1 → PRESSIONADO and fire the accept event.
  - PRESSIONADO: `press_s`=0 → CONFIRMA_SOLTURA, counter cleared.
  - CONFIRMA_SOLTURA:
    - `press_s`=1 → PRESSIONADO.
    - Otherwise count; at `DEBOUNCE_CYCLES`-1 → SOLTO.
    - No event is generated on release.
- **Accept event** (same edge as the FSM enters PRESSIONADO):
  - `pulsoBotao` is 1 for one cycle.
  - If the capture is enabled (see Configuration): `dadoCapturado` <= synchronized switches and `dadoValido` <= 1.
- **Ack.**
  - `dadoLido`=1 at a posedge clears `dadoValido`.
  - `dadoLido` while `dadoValido`=0 is ignored.
- **Simultaneous events.**
  - Accept and `dadoLido` on the same edge: new data is captured, `dadoValido` stays 1, `sobrescrita` is unchanged.
  - Accept while `dadoValido`=1 and no `dadoLido`: data is overwritten with the new value and `sobrescrita` <= 1.
  - `sobrescrita` clears only on reset.
- **Counter.** Saturating, `CNT_W` bits; it never wraps. It is cleared on every state transition.
- **Holding the key.** A held key produces exactly one pulse, no matter how long it is held.

## Timing

- **Reset values:** all outputs 0; FSM in SOLTO; counter 0; button synchronizer 1.
- **Reset mid-operation:** any state is abandoned. A key still held after reset must pass a full SOLTO → CONFIRMA_PRESS → PRESSIONADO debounce before it produces a pulse.
- **Press latency.** Define edge 0 as the first posedge sampling `botaoPlaca`=0 stable.
  - `press_s`=1 after edge 2.
  - CONFIRMA_PRESS is entered at edge 3.
  - PRESSIONADO, `pulsoBotao`, and `dadoValido` are asserted after edge 3+`DEBOUNCE_CYCLES`.
- **Data sampling.** `dadoCapturado` reflects the switches as they were 2 cycles before the accept edge.
- **Ack latency.** `dadoValido` falls on the edge that samples `dadoLido`=1; it is low from the next cycle.
- **Outputs.** All outputs are registered; there is no combinational input-to-output path.

## Configuration

- **`DEBOUNCE_GATE_PEDIDO_EN` defined:**
  - Capture occurs only if `pedidoIN`=1 on the accept edge.
  - A press while `pedidoIN`=0 still produces `pulsoBotao`, but does not change `dadoCapturado`, `dadoValido`, or `sobrescrita`.
- **`DEBOUNCE_GATE_PEDIDO_EN` undefined:** every accepted press captures data; `pedidoIN` is ignored.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. Reset=0 for 2 cycles, then release → all outputs 0. Hold `botaoPlaca`=0 with switches=4'hA → exactly one `pulsoBotao` 7 cycles after edge 0; `dadoCapturado`=4'hA and `dadoValido`=1. Hold the key 50 cycles → no second pulse.
2. Bounce: `botaoPlaca` low for 3 synchronized cycles, then high 1 cycle, repeated 5 times, then released → no pulse and `dadoValido`=0.
3. Handshake:
   - Press with switches 4'h3, then pulse `dadoLido` → `dadoValido` 0 next cycle.
   - Press again with 4'h5 → `dadoCapturado`=5, `sobrescrita`=0.
4. Overrun:
   - Two presses (4'h1, then 4'h2) without ack → `dadoCapturado`=2, `sobrescrita`=1.
   - `dadoLido` → `dadoValido`=0 and `sobrescrita` stays 1 until reset.
5. Simultaneous: `dadoLido` asserted on the exact accept edge → `dadoValido`=1 with the new data, `sobrescrita`=0.
6. With the macro defined:
   - Press with `pedidoIN`=0 → pulse only, `dadoValido`=0.
   - Press with `pedidoIN`=1 → capture.
   - Reset asserted during CONFIRMA_PRESS → outputs 0; a still-held key yields a pulse 7 cycles after reset release.
